sc_button_conditioner: RTL and testbench

SC_BUTTON_CONDITIONER -- requirements
Module: SC_BUTTON_CONDITIONER

---
 rtl/sc_button_conditioner_if.sv | 53 +++++
 rtl/sc_button_conditioner.sv | 93 +++++++++
 tb/tb_sc_button_conditioner.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_button_conditioner_if.sv
// ---------------------------------------------------------------------------
// sc_button_conditioner_if
// Groups the five raw active-low pushbuttons and the conditioned outputs of
// sc_button_conditioner into one bundle.
//   *_InLow   raw asynchronous pushbutton levels, 0 = pressed
//   *_OutLow  debounced registered levels, 0 = pressed
//   pressStrobe_OutHigh  one-cycle pulse on any debounced press
// Modports:
//   master  the side that owns the buttons and consumes the conditioned levels
//   slave   the conditioner itself
// ---------------------------------------------------------------------------
interface sc_button_conditioner_if;
  logic SC_BUTTON_CONDITIONER_startButton_InLow;
  logic SC_BUTTON_CONDITIONER_upButton_InLow;
  logic SC_BUTTON_CONDITIONER_downButton_InLow;
  logic SC_BUTTON_CONDITIONER_leftButton_InLow;
  logic SC_BUTTON_CONDITIONER_rightButton_InLow;

  logic SC_BUTTON_CONDITIONER_startButton_OutLow;
  logic SC_BUTTON_CONDITIONER_upButton_OutLow;
  logic SC_BUTTON_CONDITIONER_downButton_OutLow;
  logic SC_BUTTON_CONDITIONER_leftButton_OutLow;
  logic SC_BUTTON_CONDITIONER_rightButton_OutLow;
  logic SC_BUTTON_CONDITIONER_pressStrobe_OutHigh;

  modport master (
    output SC_BUTTON_CONDITIONER_startButton_InLow,
    output SC_BUTTON_CONDITIONER_upButton_InLow,
    output SC_BUTTON_CONDITIONER_downButton_InLow,
    output SC_BUTTON_CONDITIONER_leftButton_InLow,
    output SC_BUTTON_CONDITIONER_rightButton_InLow,
    input  SC_BUTTON_CONDITIONER_startButton_OutLow,
    input  SC_BUTTON_CONDITIONER_upButton_OutLow,
    input  SC_BUTTON_CONDITIONER_downButton_OutLow,
    input  SC_BUTTON_CONDITIONER_leftButton_OutLow,
    input  SC_BUTTON_CONDITIONER_rightButton_OutLow,
    input  SC_BUTTON_CONDITIONER_pressStrobe_OutHigh
  );

  modport slave (
    input  SC_BUTTON_CONDITIONER_startButton_InLow,
    input  SC_BUTTON_CONDITIONER_upButton_InLow,
    input  SC_BUTTON_CONDITIONER_downButton_InLow,
    input  SC_BUTTON_CONDITIONER_leftButton_InLow,
    input  SC_BUTTON_CONDITIONER_rightButton_InLow,
    output SC_BUTTON_CONDITIONER_startButton_OutLow,
    output SC_BUTTON_CONDITIONER_upButton_OutLow,
    output SC_BUTTON_CONDITIONER_downButton_OutLow,
    output SC_BUTTON_CONDITIONER_leftButton_OutLow,
    output SC_BUTTON_CONDITIONER_rightButton_OutLow,
    output SC_BUTTON_CONDITIONER_pressStrobe_OutHigh
  );
endinterface

// File: rtl/sc_button_conditioner.sv
// ---------------------------------------------------------------------------
// sc_button_conditioner
// Conditions five raw active-low pushbuttons (start, up, down, left, right).
// Each channel has a 2-flop synchronizer, a stable-level register and a
// debounce counter; a new level is accepted only after DEBOUNCE_CYCLES
// consecutive samples disagree with the current stable level. A registered
// one-cycle strobe fires whenever any channel's stable level goes 1->0.
// Ports:
//   SC_BUTTON_CONDITIONER_CLOCK_50      system clock, rising edge
//   SC_BUTTON_CONDITIONER_RESET_InHigh  synchronous active-high reset
//   bus (slave)                         raw buttons in, debounced levels and
//                                       press strobe out
// Channel bit order inside: 0 start, 1 up, 2 down, 3 left, 4 right.
// ---------------------------------------------------------------------------
module sc_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input logic                   SC_BUTTON_CONDITIONER_CLOCK_50,
  input logic                   SC_BUTTON_CONDITIONER_RESET_InHigh,
  sc_button_conditioner_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [4:0]           w_raw;
  logic [4:0]           r_sync1;
  logic [4:0]           r_sync2;
  logic [4:0]           r_stable;
  logic [4:0]           w_stableNext;
  logic [4:0]           w_mismatch;
  logic [4:0]           w_atMax;
  logic [CNT_WIDTH-1:0] r_cnt [5];
  logic                 r_pressStrobe;

  assign w_raw = {bus.SC_BUTTON_CONDITIONER_rightButton_InLow,
                  bus.SC_BUTTON_CONDITIONER_leftButton_InLow,
                  bus.SC_BUTTON_CONDITIONER_downButton_InLow,
                  bus.SC_BUTTON_CONDITIONER_upButton_InLow,
                  bus.SC_BUTTON_CONDITIONER_startButton_InLow};

  // A channel accepts the synchronized level only when it still disagrees
  // after the counter has already seen DEBOUNCE_CYCLES-1 disagreeing samples,
  // i.e. on the DEBOUNCE_CYCLES-th consecutive mismatch.
  always_comb begin
    w_mismatch   = '0;
    w_atMax      = '0;
    w_stableNext = r_stable;
    for (int i = 0; i < 5; i++) begin
      w_mismatch[i] = (r_sync2[i] != r_stable[i]);
      w_atMax[i]    = (r_cnt[i] == CNT_MAX);
      if (w_mismatch[i] && w_atMax[i]) begin
        w_stableNext[i] = r_sync2[i];
      end
    end
  end

  // Synchronizers, stable levels, counters and press strobe. The strobe is
  // raised on the same edge a stable level falls, so it is high for exactly
  // the cycle in which the new pressed level first appears on the outputs.
  // Any matching sample clears the count, so short glitches never accumulate.
  always_ff @(posedge SC_BUTTON_CONDITIONER_CLOCK_50) begin
    if (SC_BUTTON_CONDITIONER_RESET_InHigh) begin
      r_sync1       <= '1;
      r_sync2       <= '1;
      r_stable      <= '1;
      r_pressStrobe <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1       <= w_raw;
      r_sync2       <= r_sync1;
      r_stable      <= w_stableNext;
      r_pressStrobe <= |(r_stable & ~w_stableNext);
      for (int i = 0; i < 5; i++) begin
        if (!w_mismatch[i] || w_atMax[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.SC_BUTTON_CONDITIONER_startButton_OutLow  = r_stable[0];
  assign bus.SC_BUTTON_CONDITIONER_upButton_OutLow     = r_stable[1];
  assign bus.SC_BUTTON_CONDITIONER_downButton_OutLow   = r_stable[2];
  assign bus.SC_BUTTON_CONDITIONER_leftButton_OutLow   = r_stable[3];
  assign bus.SC_BUTTON_CONDITIONER_rightButton_OutLow  = r_stable[4];
  assign bus.SC_BUTTON_CONDITIONER_pressStrobe_OutHigh = r_pressStrobe;

endmodule

// File: tb/tb_sc_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sc_button_conditioner
// Self-checking bench for sc_button_conditioner with DEBOUNCE_CYCLES = 4.
// Each scenario task computes the expected outputs for every edge from the
// edge index at which the raw level is first sampled, pushes them to a
// queue, clocks the DUT and pops/compares after the edge.
// Channel bit order: 0 start, 1 up, 2 down, 3 left, 4 right.
// ---------------------------------------------------------------------------
module tb_sc_button_conditioner;

  typedef struct packed {
    logic [4:0] outs;
    logic       strobe;
  } expT;

  logic       clk;
  logic       tbRst;
  logic [4:0] tbRaw;
  logic [4:0] dutOut;
  logic       dutStrobe;
  expT        expQ [$];
  int         checks;
  int         fails;

  sc_button_conditioner_if bus ();

  sc_button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_WIDTH       (3)
  ) dut (
    .SC_BUTTON_CONDITIONER_CLOCK_50     (clk),
    .SC_BUTTON_CONDITIONER_RESET_InHigh (tbRst),
    .bus                                (bus)
  );

  assign bus.SC_BUTTON_CONDITIONER_startButton_InLow = tbRaw[0];
  assign bus.SC_BUTTON_CONDITIONER_upButton_InLow    = tbRaw[1];
  assign bus.SC_BUTTON_CONDITIONER_downButton_InLow  = tbRaw[2];
  assign bus.SC_BUTTON_CONDITIONER_leftButton_InLow  = tbRaw[3];
  assign bus.SC_BUTTON_CONDITIONER_rightButton_InLow = tbRaw[4];

  assign dutOut = {bus.SC_BUTTON_CONDITIONER_rightButton_OutLow,
                   bus.SC_BUTTON_CONDITIONER_leftButton_OutLow,
                   bus.SC_BUTTON_CONDITIONER_downButton_OutLow,
                   bus.SC_BUTTON_CONDITIONER_upButton_OutLow,
                   bus.SC_BUTTON_CONDITIONER_startButton_OutLow};
  assign dutStrobe = bus.SC_BUTTON_CONDITIONER_pressStrobe_OutHigh;

  // 100 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs on the falling edge, let one rising edge sample them, then
  // leave the outputs 1 time unit to settle before the caller looks at them.
  task automatic applyStimulus(input logic [4:0] raw, input logic rst);
    @(negedge clk);
    tbRaw = raw;
    tbRst = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(5'h1f, 1'b1);
    applyStimulus(5'h1f, 1'b0);
  endtask

  // Reset with every raw button pressed, then release reset with them held.
  task automatic test_reset();
    expT e;
    for (int k = 0; k < 9; k++) begin
      e.outs   = (k >= 7) ? 5'h00 : 5'h1f;
      e.strobe = (k == 7);
      expQ.push_back(e);
      applyStimulus(5'h00, (k < 2));
      e = expQ.pop_front();
      checks++;
      if ({dutOut, dutStrobe} !== {e.outs, e.strobe}) begin
        fails++;
        $display("[TB] FAIL reset edge %0d: got outs=%b strobe=%b, expected outs=%b strobe=%b",
                 k, dutOut, dutStrobe, e.outs, e.strobe);
      end
    end
  endtask

  task automatic test_clean_press();
    expT e;
    resetDut();
    for (int k = 0; k < 9; k++) begin
      e.outs   = (k >= 5) ? 5'b11101 : 5'h1f;
      e.strobe = (k == 5);
      expQ.push_back(e);
      applyStimulus(5'b11101, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({dutOut, dutStrobe} !== {e.outs, e.strobe}) begin
        fails++;
        $display("[TB] FAIL clean_press edge %0d: got outs=%b strobe=%b, expected outs=%b strobe=%b",
                 k, dutOut, dutStrobe, e.outs, e.strobe);
      end
    end
  endtask

  // Left pattern 0,0,0,1,0,0,0,1 then held 0; last 1->0 sample is edge 8.
  task automatic test_bounce();
    expT        e;
    logic [15:0] pat;
    logic [4:0]  raw;
    pat = 16'h0088;
    resetDut();
    for (int k = 0; k < 16; k++) begin
      raw      = 5'h1f;
      raw[3]   = pat[k];
      e.outs   = (k >= 13) ? 5'b10111 : 5'h1f;
      e.strobe = (k == 13);
      expQ.push_back(e);
      applyStimulus(raw, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({dutOut, dutStrobe} !== {e.outs, e.strobe}) begin
        fails++;
        $display("[TB] FAIL bounce edge %0d: got outs=%b strobe=%b, expected outs=%b strobe=%b",
                 k, dutOut, dutStrobe, e.outs, e.strobe);
      end
    end
  endtask

  task automatic test_release();
    expT e;
    resetDut();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(5'b11011, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      e.outs   = (k >= 5) ? 5'h1f : 5'b11011;
      e.strobe = 1'b0;
      expQ.push_back(e);
      applyStimulus(5'h1f, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({dutOut, dutStrobe} !== {e.outs, e.strobe}) begin
        fails++;
        $display("[TB] FAIL release edge %0d: got outs=%b strobe=%b, expected outs=%b strobe=%b",
                 k, dutOut, dutStrobe, e.outs, e.strobe);
      end
    end
  endtask

  task automatic test_simultaneous();
    expT e;
    resetDut();
    for (int k = 0; k < 9; k++) begin
      e.outs   = (k >= 5) ? 5'b01110 : 5'h1f;
      e.strobe = (k == 5);
      expQ.push_back(e);
      applyStimulus(5'b01110, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({dutOut, dutStrobe} !== {e.outs, e.strobe}) begin
        fails++;
        $display("[TB] FAIL simultaneous edge %0d: got outs=%b strobe=%b, expected outs=%b strobe=%b",
                 k, dutOut, dutStrobe, e.outs, e.strobe);
      end
    end
  endtask

  // Right held; reset on the 3rd mismatch edge (4); first post-reset sample at 5.
  task automatic test_reset_mid_count();
    expT e;
    resetDut();
    for (int k = 0; k < 13; k++) begin
      e.outs   = (k >= 10) ? 5'b01111 : 5'h1f;
      e.strobe = (k == 10);
      expQ.push_back(e);
      applyStimulus(5'b01111, (k == 4));
      e = expQ.pop_front();
      checks++;
      if ({dutOut, dutStrobe} !== {e.outs, e.strobe}) begin
        fails++;
        $display("[TB] FAIL reset_mid_count edge %0d: got outs=%b strobe=%b, expected outs=%b strobe=%b",
                 k, dutOut, dutStrobe, e.outs, e.strobe);
      end
    end
  endtask

  // Up held; reset lands on the edge where the count would complete.
  task automatic test_reset_priority();
    expT e;
    resetDut();
    for (int k = 0; k < 14; k++) begin
      e.outs   = (k >= 11) ? 5'b11101 : 5'h1f;
      e.strobe = (k == 11);
      expQ.push_back(e);
      applyStimulus(5'b11101, (k == 5));
      e = expQ.pop_front();
      checks++;
      if ({dutOut, dutStrobe} !== {e.outs, e.strobe}) begin
        fails++;
        $display("[TB] FAIL reset_priority edge %0d: got outs=%b strobe=%b, expected outs=%b strobe=%b",
                 k, dutOut, dutStrobe, e.outs, e.strobe);
      end
    end
  endtask

  // Up pressed at edge 0, down added at edge 3 while up stays held.
  task automatic test_back_to_back();
    expT        e;
    logic [4:0] raw;
    resetDut();
    for (int k = 0; k < 12; k++) begin
      raw      = (k < 3) ? 5'b11101 : 5'b11001;
      e.outs   = 5'h1f;
      e.outs[1] = (k >= 5) ? 1'b0 : 1'b1;
      e.outs[2] = (k >= 8) ? 1'b0 : 1'b1;
      e.strobe = (k == 5) || (k == 8);
      expQ.push_back(e);
      applyStimulus(raw, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({dutOut, dutStrobe} !== {e.outs, e.strobe}) begin
        fails++;
        $display("[TB] FAIL back_to_back edge %0d: got outs=%b strobe=%b, expected outs=%b strobe=%b",
                 k, dutOut, dutStrobe, e.outs, e.strobe);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    tbRaw  = 5'h1f;
    tbRst  = 1'b1;
    $display("[TB] starting sc_button_conditioner bench");
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    test_reset_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
